// File: rtl/sap_control_sequencer.sv
// ---------------------------------------------------------------------------
// sap_control_sequencer
// Control sequencer for the SAP-U CPU. It contains a six-phase one-hot ring
// counter (T1..T6) and an opcode decoder that drive the datapath control word.
//
// Ports
//   clk       in   system clock, rising edge
//   clear     in   synchronous active-high reset
//   opcode    in   [3:0] IR[7:4], the current instruction opcode
//   run_mode  in   1 = advance every cycle, 0 = advance on a step edge only
//   step      in   debounced, synchronous single-step button
//   t_state   out  [5:0] one-hot phase (bit0 = T1 ... bit5 = T6)
//   cp ep lm ce li ei la ea su eu lb lo
//             out  control word: combinational decode of the phase and opcode
//   halted    out  CPU halted; only clear releases it
// ---------------------------------------------------------------------------
module sap_control_sequencer #(
  parameter bit EARLY_FETCH = 1'b1
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [3:0] opcode,
  input  logic       run_mode,
  input  logic       step,
  output logic [5:0] t_state,
  output logic       cp,
  output logic       ep,
  output logic       lm,
  output logic       ce,
  output logic       li,
  output logic       ei,
  output logic       la,
  output logic       ea,
  output logic       su,
  output logic       eu,
  output logic       lb,
  output logic       lo,
  output logic       halted
);

  localparam int unsigned TW = 6;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [TW-1:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_e;

  tstate_e state_q, state_d;
  logic    halted_q, halted_d;
  logic    step_q;
  logic    adv;
  logic    is_last;
  logic    state_legal;

  // One advance per run cycle or per rising edge of the step button.
  assign adv = run_mode | (step & ~step_q);

  assign state_legal = state_q inside {T1, T2, T3, T4, T5, T6};

  // Last active phase of the current instruction (used for early fetch).
  always_comb begin
    is_last = 1'b0;
    case (opcode)
      OP_LDA:         is_last = (state_q == T5);
      OP_ADD, OP_SUB: is_last = (state_q == T6);
      OP_OUT:         is_last = (state_q == T4);
      OP_HLT:         is_last = 1'b0;
      default:        is_last = (state_q == T3);
    endcase
  end

  // Next phase and halt flag.
  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    if (!state_legal) begin
      state_d = T1;
    end else if (halted_q) begin
      state_d = state_q;
    end else if (adv) begin
      if (opcode == OP_HLT && state_q == T4) begin
        // HLT parks the ring in T4 for good.
        halted_d = 1'b1;
        state_d  = T4;
      end else if (EARLY_FETCH && is_last) begin
        state_d = T1;
      end else begin
        case (state_q)
          T1:      state_d = T2;
          T2:      state_d = T3;
          T3:      state_d = T4;
          T4:      state_d = T5;
          T5:      state_d = T6;
          T6:      state_d = T1;
          default: state_d = T1;
        endcase
      end
    end
  end

  // State registers; clear wins over halt and over adv.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q  <= T1;
      halted_q <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
      step_q   <= step;
    end
  end

  // Control word decode; silent while clearing or halted.
  always_comb begin
    cp = 1'b0;
    ep = 1'b0;
    lm = 1'b0;
    ce = 1'b0;
    li = 1'b0;
    ei = 1'b0;
    la = 1'b0;
    ea = 1'b0;
    su = 1'b0;
    eu = 1'b0;
    lb = 1'b0;
    lo = 1'b0;
    if (!clear && !halted_q) begin
      case (state_q)
        T1: begin
          ep = 1'b1;
          lm = 1'b1;
        end
        T2: cp = 1'b1;
        T3: begin
          ce = 1'b1;
          li = 1'b1;
        end
        T4: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              ei = 1'b1;
              lm = 1'b1;
            end
            OP_OUT: begin
              ea = 1'b1;
              lo = 1'b1;
            end
            default: ;
          endcase
        end
        T5: begin
          case (opcode)
            OP_LDA: begin
              ce = 1'b1;
              la = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ce = 1'b1;
              lb = 1'b1;
            end
            default: ;
          endcase
        end
        T6: begin
          case (opcode)
            OP_ADD: begin
              eu = 1'b1;
              la = 1'b1;
            end
            OP_SUB: begin
              su = 1'b1;
              eu = 1'b1;
              la = 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign t_state = state_q;
  assign halted  = halted_q;

endmodule

// File: tb/tb_sap_control_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sap_control_sequencer
// Scoreboard bench: each driven cycle pushes the expected phase, control word
// and halt flag; a negedge monitor pops and compares against the selected DUT.
// DUT a uses EARLY_FETCH=1, DUT b uses EARLY_FETCH=0; both share stimulus.
// ---------------------------------------------------------------------------
module tb_sap_control_sequencer;

  localparam logic [5:0] S1 = 6'b000001;
  localparam logic [5:0] S2 = 6'b000010;
  localparam logic [5:0] S3 = 6'b000100;
  localparam logic [5:0] S4 = 6'b001000;
  localparam logic [5:0] S5 = 6'b010000;
  localparam logic [5:0] S6 = 6'b100000;

  // Control word packing: {cp,ep,lm,ce,li,ei,la,ea,su,eu,lb,lo}
  localparam logic [11:0] CP = 12'h800;
  localparam logic [11:0] EP = 12'h400;
  localparam logic [11:0] LM = 12'h200;
  localparam logic [11:0] CE = 12'h100;
  localparam logic [11:0] LI = 12'h080;
  localparam logic [11:0] EI = 12'h040;
  localparam logic [11:0] LA = 12'h020;
  localparam logic [11:0] EA = 12'h010;
  localparam logic [11:0] SU = 12'h008;
  localparam logic [11:0] EU = 12'h004;
  localparam logic [11:0] LB = 12'h002;
  localparam logic [11:0] LO = 12'h001;
  localparam logic [11:0] NONE = 12'h000;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_NOP = 4'h5;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam bit DA = 1'b1;
  localparam bit DB = 1'b0;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic [3:0] opcode = 4'h0;
  logic       run_mode = 1'b0;
  logic       step = 1'b0;

  logic [5:0]  t_a, t_b;
  logic        h_a, h_b;
  logic        cp_a, ep_a, lm_a, ce_a, li_a, ei_a, la_a, ea_a, su_a, eu_a, lb_a, lo_a;
  logic        cp_b, ep_b, lm_b, ce_b, li_b, ei_b, la_b, ea_b, su_b, eu_b, lb_b, lo_b;
  logic [11:0] c_a, c_b;

  assign c_a = {cp_a, ep_a, lm_a, ce_a, li_a, ei_a, la_a, ea_a, su_a, eu_a, lb_a, lo_a};
  assign c_b = {cp_b, ep_b, lm_b, ce_b, li_b, ei_b, la_b, ea_b, su_b, eu_b, lb_b, lo_b};

  always #5 clk = ~clk;

  sap_control_sequencer #(.EARLY_FETCH(1'b1)) u_dut_a (
    .clk(clk), .clear(clear), .opcode(opcode), .run_mode(run_mode), .step(step),
    .t_state(t_a), .cp(cp_a), .ep(ep_a), .lm(lm_a), .ce(ce_a), .li(li_a),
    .ei(ei_a), .la(la_a), .ea(ea_a), .su(su_a), .eu(eu_a), .lb(lb_a), .lo(lo_a),
    .halted(h_a)
  );

  sap_control_sequencer #(.EARLY_FETCH(1'b0)) u_dut_b (
    .clk(clk), .clear(clear), .opcode(opcode), .run_mode(run_mode), .step(step),
    .t_state(t_b), .cp(cp_b), .ep(ep_b), .lm(lm_b), .ce(ce_b), .li(li_b),
    .ei(ei_b), .la(la_b), .ea(ea_b), .su(su_b), .eu(eu_b), .lb(lb_b), .lo(lo_b),
    .halted(h_b)
  );

  typedef struct {
    bit          sel;
    logic [5:0]  t;
    logic [11:0] c;
    logic        h;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs without an expectation.
  task automatic drive(input logic c, input logic r, input logic s, input logic [3:0] op);
    @(posedge clk);
    #1;
    clear    = c;
    run_mode = r;
    step     = s;
    opcode   = op;
  endtask

  // Drive one cycle and push what the selected DUT must show during it.
  task automatic cyc(input logic c, input logic r, input logic s, input logic [3:0] op,
                     input bit sel, input logic [5:0] et, input logic [11:0] ec,
                     input logic eh, input string tag);
    exp_t e;
    drive(c, r, s, op);
    e.sel = sel;
    e.t   = et;
    e.c   = ec;
    e.h   = eh;
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      if (mon_e.sel) begin
        check_eq({mon_e.tag, "/t_state"}, 32'(t_a), 32'(mon_e.t));
        check_eq({mon_e.tag, "/ctrl"},    32'(c_a), 32'(mon_e.c));
        check_eq({mon_e.tag, "/halted"},  32'(h_a), 32'(mon_e.h));
      end else begin
        check_eq({mon_e.tag, "/t_state"}, 32'(t_b), 32'(mon_e.t));
        check_eq({mon_e.tag, "/ctrl"},    32'(c_b), 32'(mon_e.c));
        check_eq({mon_e.tag, "/halted"},  32'(h_b), 32'(mon_e.h));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and LDA with early fetch: T6 never visited.
    drive(1, 1, 0, OP_LDA);
    cyc(1, 1, 0, OP_LDA, DA, S1, NONE,    0, "rst_hold");
    cyc(0, 1, 0, OP_LDA, DA, S1, EP | LM, 0, "lda_t1");
    cyc(0, 1, 0, OP_LDA, DA, S2, CP,      0, "lda_t2");
    cyc(0, 1, 0, OP_LDA, DA, S3, CE | LI, 0, "lda_t3");
    cyc(0, 1, 0, OP_LDA, DA, S4, EI | LM, 0, "lda_t4");
    cyc(0, 1, 0, OP_LDA, DA, S5, CE | LA, 0, "lda_t5");
    cyc(0, 1, 0, OP_NOP, DA, S1, EP | LM, 0, "lda_wrap");
    // NOP with early fetch ends after T3.
    cyc(0, 1, 0, OP_NOP, DA, S2, CP,      0, "nop_t2");
    cyc(0, 1, 0, OP_NOP, DA, S3, CE | LI, 0, "nop_t3");
    cyc(0, 1, 0, OP_OUT, DA, S1, EP | LM, 0, "nop_wrap");
    // OUT with early fetch ends after T4.
    cyc(0, 1, 0, OP_OUT, DA, S2, CP,      0, "outa_t2");
    cyc(0, 1, 0, OP_OUT, DA, S3, CE | LI, 0, "outa_t3");
    cyc(0, 1, 0, OP_OUT, DA, S4, EA | LO, 0, "outa_t4");
    cyc(0, 1, 0, OP_OUT, DA, S1, EP | LM, 0, "outa_wrap");

    // SUB then OUT on the full-ring DUT.
    drive(1, 1, 0, OP_SUB);
    cyc(1, 1, 0, OP_SUB, DB, S1, NONE,         0, "rstb_hold");
    cyc(0, 1, 0, OP_SUB, DB, S1, EP | LM,      0, "sub_t1");
    cyc(0, 1, 0, OP_SUB, DB, S2, CP,           0, "sub_t2");
    cyc(0, 1, 0, OP_SUB, DB, S3, CE | LI,      0, "sub_t3");
    cyc(0, 1, 0, OP_SUB, DB, S4, EI | LM,      0, "sub_t4");
    cyc(0, 1, 0, OP_SUB, DB, S5, CE | LB,      0, "sub_t5");
    cyc(0, 1, 0, OP_SUB, DB, S6, SU | EU | LA, 0, "sub_t6");
    cyc(0, 1, 0, OP_OUT, DB, S1, EP | LM,      0, "sub_wrap");
    cyc(0, 1, 0, OP_OUT, DB, S2, CP,           0, "outb_t2");
    cyc(0, 1, 0, OP_OUT, DB, S3, CE | LI,      0, "outb_t3");
    cyc(0, 1, 0, OP_OUT, DB, S4, EA | LO,      0, "outb_t4");
    cyc(0, 1, 0, OP_OUT, DB, S5, NONE,         0, "outb_t5");
    cyc(0, 1, 0, OP_OUT, DB, S6, NONE,         0, "outb_t6");
    cyc(0, 1, 0, OP_ADD, DB, S1, EP | LM,      0, "outb_wrap");

    // Single step: a held button advances once; mode switching; mid-ADD clear.
    drive(1, 0, 0, OP_ADD);
    cyc(1, 0, 0, OP_ADD, DA, S1, NONE, 0, "rstc_hold");
    for (int i = 0; i < 5; i++)
      cyc(0, 0, 1, OP_ADD, DA, (i == 0) ? S1 : S2, (i == 0) ? (EP | LM) : CP, 0, "step_hold");
    cyc(0, 0, 0, OP_ADD, DA, S2, CP,      0, "step_rel");
    cyc(0, 0, 1, OP_ADD, DA, S2, CP,      0, "step_press2");
    cyc(0, 0, 0, OP_ADD, DA, S3, CE | LI, 0, "step_t3");
    cyc(0, 1, 1, OP_ADD, DA, S3, CE | LI, 0, "run_and_step");
    cyc(0, 1, 1, OP_ADD, DA, S4, EI | LM, 0, "single_adv");
    cyc(0, 1, 0, OP_ADD, DA, S5, CE | LB, 0, "add_t5");
    cyc(1, 1, 0, OP_ADD, DA, S6, NONE,    0, "clr_in_t6");
    cyc(0, 0, 0, OP_ADD, DA, S1, EP | LM, 0, "after_clr");
    cyc(0, 1, 0, OP_ADD, DA, S1, EP | LM, 0, "hold_then_run");
    cyc(0, 1, 0, OP_ADD, DA, S2, CP,      0, "mode_run");
    cyc(0, 1, 0, OP_ADD, DA, S3, CE | LI, 0, "mode_run2");
    cyc(0, 1, 0, OP_ADD, DA, S4, EI | LM, 0, "add_t4");
    cyc(1, 0, 0, OP_ADD, DA, S5, NONE,    0, "clr_in_t5");
    cyc(0, 0, 0, OP_ADD, DA, S1, EP | LM, 0, "after_clr_t5");
    cyc(0, 0, 0, OP_ADD, DA, S1, EP | LM, 0, "run_off_hold");

    // HLT: freezes in T4 regardless of run/step until clear.
    drive(1, 1, 0, OP_HLT);
    cyc(1, 1, 0, OP_HLT, DA, S1, NONE,    0, "rstd_hold");
    cyc(0, 1, 0, OP_HLT, DA, S1, EP | LM, 0, "hlt_t1");
    cyc(0, 1, 0, OP_HLT, DA, S2, CP,      0, "hlt_t2");
    cyc(0, 1, 0, OP_HLT, DA, S3, CE | LI, 0, "hlt_t3");
    cyc(0, 1, 0, OP_HLT, DA, S4, NONE,    0, "hlt_t4");
    for (int i = 0; i < 20; i++)
      cyc(0, 1, 1'(i & 1), (i < 10) ? OP_HLT : OP_ADD, DA, S4, NONE, 1, "halted");
    cyc(1, 1, 0, OP_ADD, DA, S4, NONE,    1, "hlt_clr");
    cyc(0, 0, 0, OP_ADD, DA, S1, EP | LM, 0, "hlt_released");

    @(negedge clk);
    #1;
    for (int i = 0; i < 4 && sb_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb_q.size() != 0)
      check_eq("drain", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
